ysyx_23060061_ifu: RTL

Instruction fetch unit: owns the architectural PC, issues one word read per instruction to instruction memory over a valid/ready request plus valid response channel, and holds the fetched word for the decode/execute stage directly downstream. It consumes that stage's branch/jump outcome (PC select plus target) at the moment the held instruction retires, and stops permanently on ebreak. Single-issue, one instruction in flight.

---
 rtl/ysyx_23060061_ifu.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ysyx_23060061_ifu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060061_ifu
// Purpose  : Instruction fetch unit. Owns the architectural PC, issues one
//            word read per instruction over a valid/ready request channel,
//            captures the response and holds it for the downstream stage
//            until it retires. Applies the retiring instruction's redirect
//            and stops permanently on halt (ebreak).
// Ports    : clk, rst (async, active-high)
//            imem_req_valid/imem_req_addr/imem_req_ready : fetch request
//            imem_rsp_valid/imem_rsp_data                : fetch response
//            inst_valid/inst/inst_pc/inst_ready          : held instruction
//            redirect/redirect_pc/halt                   : retire outcome
//            halted, inst_count, misalign_err            : status
// Options  : YSYX_23060061_IFU_MISALIGN_CHECK_EN - when defined, a redirect
//            to a non word-aligned target sets sticky misalign_err and halts;
//            otherwise the low two target bits are cleared.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060061_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        halted,
    output logic [31:0] inst_count,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic        r_reqValid;
    logic [31:0] r_pc;
    logic [31:0] w_nextPc;
    logic [31:0] r_inst;
    logic [31:0] r_instPc;
    logic [31:0] r_instCount;

    logic        w_accept;
    logic        w_rspTake;
    logic        w_retire;
    logic        w_badTarget;
    logic [31:0] w_target;

    // The request is only live once r_reqValid is up; this keeps the request
    // low while reset is held and for the REQ cycle entered out of reset.
    assign w_accept  = (r_state == S_REQ) && r_reqValid && imem_req_ready;
    assign w_rspTake = (r_state == S_WAIT) && imem_rsp_valid;
    assign w_retire  = (r_state == S_HOLD) && inst_ready;
    assign w_target  = redirect_pc & 32'hFFFF_FFFC;

`ifdef YSYX_23060061_IFU_MISALIGN_CHECK_EN
    logic r_misalign;
    assign w_badTarget  = redirect && (redirect_pc[1:0] != 2'b00);
    assign misalign_err = r_misalign;
`else
    assign w_badTarget  = 1'b0;
    assign misalign_err = 1'b0;
`endif

    always_comb begin
        w_nextState = r_state;
        w_nextPc    = r_pc;
        case (r_state)
            S_REQ: begin
                if (w_accept) begin
                    w_nextState = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_rspTake) begin
                    w_nextState = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_retire) begin
                    // halt wins over redirect; a bad target freezes the PC
                    if (halt || w_badTarget) begin
                        w_nextState = S_HALT;
                    end else begin
                        w_nextState = S_REQ;
                        w_nextPc    = redirect ? w_target : (r_pc + 32'd4);
                    end
                end
            end
            S_HALT: begin
                w_nextState = S_HALT;
            end
            default: begin
                w_nextState = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_REQ;
            r_reqValid  <= 1'b0;
            r_pc        <= RESET_PC;
            r_inst      <= 32'd0;
            r_instPc    <= RESET_PC;
            r_instCount <= 32'd0;
        end else begin
            r_state    <= w_nextState;
            r_reqValid <= (w_nextState == S_REQ);
            r_pc       <= w_nextPc;
            if (w_rspTake) begin
                r_inst   <= imem_rsp_data;
                r_instPc <= r_pc;
            end
            if (w_retire) begin
                r_instCount <= r_instCount + 32'd1;
            end
        end
    end

`ifdef YSYX_23060061_IFU_MISALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else if (w_retire && !halt && w_badTarget) begin
            r_misalign <= 1'b1;
        end
    end
`endif

    assign imem_req_valid = r_reqValid;
    assign imem_req_addr  = r_pc;
    assign inst_valid     = (r_state == S_HOLD);
    assign inst           = r_inst;
    assign inst_pc        = r_instPc;
    assign halted         = (r_state == S_HALT);
    assign inst_count     = r_instCount;

endmodule
`default_nettype wire
